plotter_pixel_feeder: RTL and testbench
=======================================

// Module: plotter_pixel_feeder
// PURPOSE
//  Upstream feeder for the plotter controller. Walks a grayscale frame stored in BRAM in raster order,
//  one pixel per cell. Thresholds each pixel to 1 bit and presents it on pixel_value_out.
//  Advances on each rising edge of the plotter's ready_next_pixel. Drives the plotter's enable_plotter
//  through pixel_valid.
// PARAMETERS
//  COLS    80   pixels per plotted line (720 steps / 9)
//  ROWS    106  plotted lines (960 steps / 9, rounded down)
//  ADDR_W  14   BRAM address width; COLS*ROWS must be <= 2**ADDR_W
//  PIX_W   8    grayscale sample width
//  RD_LAT  2    BRAM read latency in clk_65mhz cycles (1..3)
// PORTS
//  clk_65mhz         in   1       system clock
//  rst               in   1       reset: asynchronous, active-high
//  start             in   1       1-cycle pulse; begins a frame from IDLE or DONE
//  threshold         in   PIX_W   a pixel is drawn (1) when sample < threshold (dark = ink)
//  ready_next_pixel  in   1       from plotter; rising edge = presented pixel consumed
//  drawing_done      in   1       from plotter; level, plot finished
//  bram_addr         out  ADDR_W  frame read address
//  bram_dout         in   PIX_W   frame read data, valid RD_LAT cycles after bram_addr
//  pixel_value_out   out  1       thresholded pixel; goes to the plotter's pixel_value_in
//  pixel_valid       out  1       pixel_value_out valid; goes to the plotter's enable_plotter
//  col_idx           out  7       column of the presented pixel
//  row_idx           out  7       row of the presented pixel
//  frame_done        out  1       level; last pixel consumed or drawing_done seen
//  underrun          out  1       sticky; a consume edge arrived while pixel_valid=0
// BEHAVIOUR
//  Reset values: every output is 0, the FSM is in IDLE, and the ready edge register is 0.
//  Reset mid-frame aborts immediately; the next frame needs a new start.
//  Consume edge:
//   - consume = ready_next_pixel & ~ready_q.
//   - ready_q is registered every cycle in every state.
//  FSM states:
//   - IDLE: outputs idle.
//     - start: addr=0, col=0, row=0, go to FETCH.
//   - FETCH: drive bram_addr for one cycle, load lat_ctr=RD_LAT-1, go to WAIT.
//   - WAIT: decrement lat_ctr.
//     - At 0: register pixel_value_out from bram_dout, set pixel_valid=1, go to PRESENT.
//     - First output valid RD_LAT+1 cycles after entering FETCH.
//   - PRESENT: hold pixel_value_out and pixel_valid.
//     - On consume at the last pixel (col=COLS-1 and row=ROWS-1): pixel_valid=0, go to DONE.
//     - On any other consume: pixel_valid=0, go to FETCH, addr+1.
//       - col+1; at col=COLS-1, col wraps to 0 and row+1.
//     - Address is incremental; there is no multiplier.
//   - DONE: frame_done=1, pixel_valid=0.
//     - start: clear frame_done, restart the frame at addr 0.
//  drawing_done=1 in any non-IDLE state: go to DONE at the next cycle. This takes priority over consume.
//  Consume in FETCH or WAIT:
//   - Set underrun.
//   - Do not advance; the edge is dropped.
//   - underrun clears only on rst or start.
//  Consume in IDLE or DONE is ignored.
//  start outside IDLE and DONE is ignored.
//  start and consume in the same cycle in DONE: start wins.
//  Compare: pixel_value_out = (sample < threshold). threshold=0 gives all zeros; threshold is sampled in WAIT.
// CONFIGURATION
//  FEEDER_DITHER_EN
//   - Defined: a 2x2 ordered dither is applied.
//     - eff_thr = sat(threshold + BAYER[row[0]][col[0]] - 32).
//     - BAYER = {{0,32},{48,16}}, clamped to the range 0..2**PIX_W-1.
//   - Undefined: eff_thr = threshold.
// STRUCTURE
//  Package plotter_pkg holds:
//   - the feeder_state_t enum {IDLE,FETCH,WAIT,PRESENT,DONE}
//   - the COLS/ROWS defaults
//   - the BAYER table
//  Sub-module pixel_threshold: combinational sample/threshold/dither compare, registered by the FSM.
// TESTING
//  T1 All-black frame, threshold=128:
//   - start, then 8480 consume edges -> 8480 ones.
//   - frame_done after the last edge; bram_addr ends at 8479.
//  T2 Ramp frame (sample = addr[7:0]), threshold=100:
//   - pixel at col 5 of row 0 is 1; pixel at col 101-80=21 of row 1 (addr 101) is 0.
//   - col/row wrap 79 -> 0 and row 0 -> 1.
//  T3 Consume pulse 1 cycle after the previous consume (during WAIT):
//   - underrun=1, address unchanged.
//   - The next valid consume advances by exactly one.
//  T4 rst asserted mid-frame at addr 300:
//   - all outputs 0 asynchronously.
//   - After start, first bram_addr=0; pixel_valid rises RD_LAT+1 cycles after leaving IDLE.
//  T5 drawing_done asserted at addr 40: frame_done=1 next cycle, pixel_valid=0, no further reads.
//  T6 With FEEDER_DITHER_EN, flat sample=120, threshold=128: 2x2 pattern is (0,1)/(1,0) by row/col parity.

Source files
------------

// File: rtl/plotter_pkg.sv
// rtl/plotter_pkg.sv - shared state type, frame geometry and dither table for the pixel feeder
package plotter_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, DONE} feeder_state_t;

  localparam int COLS_DEFAULT = 80;
  localparam int ROWS_DEFAULT = 106;

  // 2x2 ordered dither offsets, indexed [row parity][column parity]
  localparam int BAYER [2][2] = '{'{0, 32}, '{48, 16}};
  localparam int BAYER_BIAS = 32;

endpackage

// File: rtl/pixel_threshold.sv
// rtl/pixel_threshold.sv - combinational sample-vs-threshold compare (ink when darker)
// FEEDER_DITHER_EN adds a 2x2 ordered dither to the threshold.
module pixel_threshold
  import plotter_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] sample,
  input  logic [PIX_W-1:0] threshold,
  input  logic             row_lsb,
  input  logic             col_lsb,
  output logic             pixel
);

`ifdef FEEDER_DITHER_EN
  localparam int PIX_MAX = (1 << PIX_W) - 1;

  int eff_thr;

  always_comb begin
    eff_thr = int'(threshold) + BAYER[row_lsb][col_lsb] - BAYER_BIAS;
    if (eff_thr < 0) begin
      eff_thr = 0;
    end else if (eff_thr > PIX_MAX) begin
      eff_thr = PIX_MAX;
    end
    pixel = (int'(sample) < eff_thr);
  end
`else
  logic unused_parity;

  assign unused_parity = row_lsb ^ col_lsb;
  assign pixel         = (sample < threshold);
`endif

endmodule

// File: rtl/plotter_pixel_feeder.sv
// rtl/plotter_pixel_feeder.sv - raster-order BRAM walker feeding 1-bit pixels to the plotter
// Optional ordered dither under FEEDER_DITHER_EN (see pixel_threshold).
module plotter_pixel_feeder
  import plotter_pkg::*;
#(
  parameter int COLS   = COLS_DEFAULT,
  parameter int ROWS   = ROWS_DEFAULT,
  parameter int ADDR_W = 14,
  parameter int PIX_W  = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk_65mhz,
  input  logic              rst,
  input  logic              start,
  input  logic [PIX_W-1:0]  threshold,
  input  logic              ready_next_pixel,
  input  logic              drawing_done,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [PIX_W-1:0]  bram_dout,
  output logic              pixel_value_out,
  output logic              pixel_valid,
  output logic [6:0]        col_idx,
  output logic [6:0]        row_idx,
  output logic              frame_done,
  output logic              underrun
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [6:0] LAST_ROW = 7'(ROWS - 1);
  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  feeder_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [6:0]        col_q, col_d;
  logic [6:0]        row_q, row_d;
  logic [1:0]        lat_q, lat_d;
  logic              pix_q, pix_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;
  logic              ready_q;
  logic              consume;
  logic              last_pixel;
  logic              thr_pixel;

  assign consume    = ready_next_pixel & ~ready_q;
  assign last_pixel = (col_q == LAST_COL) && (row_q == LAST_ROW);

  pixel_threshold #(.PIX_W(PIX_W)) u_threshold (
    .sample    (bram_dout),
    .threshold (threshold),
    .row_lsb   (row_q[0]),
    .col_lsb   (col_q[0]),
    .pixel     (thr_pixel)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    col_d      = col_q;
    row_d      = row_q;
    lat_d      = lat_q;
    pix_d      = pix_q;
    valid_d    = valid_q;
    done_d     = done_q;
    underrun_d = underrun_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = FETCH;
          addr_d     = '0;
          col_d      = '0;
          row_d      = '0;
          valid_d    = 1'b0;
          done_d     = 1'b0;
          underrun_d = 1'b0;
        end
      end
      FETCH: begin
        lat_d   = LAT_LOAD;
        state_d = WAIT;
        if (consume) underrun_d = 1'b1;
      end
      WAIT: begin
        if (consume) underrun_d = 1'b1;
        if (lat_q == 2'd0) begin
          pix_d   = thr_pixel;
          valid_d = 1'b1;
          state_d = PRESENT;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      PRESENT: begin
        if (consume) begin
          valid_d = 1'b0;
          if (last_pixel) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
            addr_d  = addr_q + ADDR_W'(1);
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + 7'd1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Plotter finishing early overrides any pending advance; a restart from DONE still wins.
    if (drawing_done && (state_q != IDLE) && !((state_q == DONE) && start)) begin
      state_d = DONE;
      done_d  = 1'b1;
      valid_d = 1'b0;
      addr_d  = addr_q;
      col_d   = col_q;
      row_d   = row_q;
    end
  end

  always_ff @(posedge clk_65mhz or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      lat_q      <= '0;
      pix_q      <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      lat_q      <= lat_d;
      pix_q      <= pix_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      ready_q    <= ready_next_pixel;
    end
  end

  assign bram_addr       = addr_q;
  assign col_idx         = col_q;
  assign row_idx         = row_q;
  assign pixel_value_out = pix_q;
  assign pixel_valid     = valid_q;
  assign frame_done      = done_q;
  assign underrun        = underrun_q;

endmodule

// File: tb/tb_plotter_pixel_feeder.sv
// tb/tb_plotter_pixel_feeder.sv - table-driven and randomized bench for plotter_pixel_feeder
module tb_plotter_pixel_feeder;

  localparam int COLS   = 80;
  localparam int ROWS   = 106;
  localparam int ADDR_W = 14;
  localparam int PIX_W  = 8;
  localparam int RD_LAT = 2;
  localparam int NPIX   = COLS * ROWS;

  logic              clk_65mhz = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [PIX_W-1:0]  threshold = '0;
  logic              ready_next_pixel = 1'b0;
  logic              drawing_done = 1'b0;
  logic [ADDR_W-1:0] bram_addr;
  logic [PIX_W-1:0]  bram_dout;
  logic              pixel_value_out;
  logic              pixel_valid;
  logic [6:0]        col_idx;
  logic [6:0]        row_idx;
  logic              frame_done;
  logic              underrun;

  logic [PIX_W-1:0]  mem [0:(1<<ADDR_W)-1];
  logic [PIX_W-1:0]  rd_pipe0, rd_pipe1;

  int n_checks = 0;
  int n_fail   = 0;
  int cur      = 0;

  typedef struct {
    int thr;
    int sample;
    int exp;
  } vec_t;

  vec_t vecs [8];

  plotter_pixel_feeder #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk_65mhz        (clk_65mhz),
    .rst              (rst),
    .start            (start),
    .threshold        (threshold),
    .ready_next_pixel (ready_next_pixel),
    .drawing_done     (drawing_done),
    .bram_addr        (bram_addr),
    .bram_dout        (bram_dout),
    .pixel_value_out  (pixel_value_out),
    .pixel_valid      (pixel_valid),
    .col_idx          (col_idx),
    .row_idx          (row_idx),
    .frame_done       (frame_done),
    .underrun         (underrun)
  );

  always #8 clk_65mhz = ~clk_65mhz;

  // Two-cycle read latency BRAM model
  always @(posedge clk_65mhz) begin
    rd_pipe0 <= mem[bram_addr];
    rd_pipe1 <= rd_pipe0;
  end
  assign bram_dout = rd_pipe1;

  function automatic int exp_pix(input int sample, input int thr, input int row, input int col);
    int eff;
    eff = thr;
`ifdef FEEDER_DITHER_EN
    if (row % 2 == 0) eff = eff + ((col % 2 == 0) ? 0 : 32);
    else              eff = eff + ((col % 2 == 0) ? 48 : 16);
    eff = eff - 32;
    if (eff < 0)   eff = 0;
    if (eff > 255) eff = 255;
`endif
    return (sample < eff) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk_65mhz);
  endtask

  task automatic do_reset;
    ready_next_pixel = 1'b0;
    drawing_done     = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    cur = 0;
  endtask

  task automatic wait_valid;
    int n;
    n = 0;
    while (!pixel_valid && n < 40) begin
      tick;
      n++;
    end
    if (!pixel_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic consume;
    ready_next_pixel = 1'b1;
    tick;
    ready_next_pixel = 1'b0;
  endtask

  task automatic check_pixel(input int i);
    check("pix_value", int'(pixel_value_out), exp_pix(int'(mem[i]), int'(threshold), i / COLS, i % COLS));
    check("col_idx", int'(col_idx), i % COLS);
    check("row_idx", int'(row_idx), i / COLS);
    check("bram_addr", int'(bram_addr), i);
  endtask

  task automatic advance;
    consume;
    cur++;
    wait_valid;
    check_pixel(cur);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  int'(bram_addr), 0);
    check({tag, "_pix"},   int'(pixel_value_out), 0);
    check({tag, "_valid"}, int'(pixel_valid), 0);
    check({tag, "_col"},   int'(col_idx), 0);
    check({tag, "_row"},   int'(row_idx), 0);
    check({tag, "_done"},  int'(frame_done), 0);
    check({tag, "_under"}, int'(underrun), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    int ones;
    int n;

    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;

    // Reset state
    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    tick;
    rst = 1'b0;
    tick;
    consume;
    tick;
    consume;
    check("idle_consume_under", int'(underrun), 0);
    check("idle_consume_valid", int'(pixel_valid), 0);

    // Table-driven single-pixel thresholds at (row 0, col 0)
    vecs[0] = '{128, 0,   1};
    vecs[1] = '{128, 255, 0};
    vecs[2] = '{0,   0,   0};
    vecs[3] = '{255, 254, 1};
    vecs[4] = '{255, 255, 0};
    vecs[5] = '{100, 99,  1};
    vecs[6] = '{100, 100, 0};
    vecs[7] = '{1,   0,   1};
    for (int v = 0; v < 8; v++) begin
      mem[0]    = 8'(vecs[v].sample);
      threshold = 8'(vecs[v].thr);
      do_reset;
      do_start;
      wait_valid;
`ifdef FEEDER_DITHER_EN
      check("vec_pix", int'(pixel_value_out), exp_pix(vecs[v].sample, vecs[v].thr, 0, 0));
`else
      check("vec_pix", int'(pixel_value_out), vecs[v].exp);
`endif
    end

    // Ramp frame, threshold 100, with wrap checks
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i);
    threshold = 8'd100;
    do_reset;
    do_start;
    wait_valid;
    check_pixel(0);
    while (cur < 102) begin
      advance;
      if (cur == 5)   check("t2_col5_row0", int'(pixel_value_out), 1);
      if (cur == 101) check("t2_addr101", int'(pixel_value_out), 0);
      if (cur == 79)  check("t2_last_col", int'(col_idx), 79);
      if (cur == 80)  check("t2_wrap_row", int'(row_idx), 1);
    end

    // Consume edge while the next pixel is still being fetched
    ready_next_pixel = 1'b1;
    tick;
    ready_next_pixel = 1'b0;
    tick;
    ready_next_pixel = 1'b1;
    tick;
    ready_next_pixel = 1'b0;
    check("t3_underrun", int'(underrun), 1);
    check("t3_addr_hold", int'(bram_addr), 103);
    cur = 103;
    wait_valid;
    check_pixel(103);
    advance;
    check("t3_under_sticky", int'(underrun), 1);

    // Early drawing_done, then restart with a same-cycle consume
    drawing_done = 1'b1;
    tick;
    drawing_done = 1'b0;
    check("dd_frame_done", int'(frame_done), 1);
    check("dd_valid", int'(pixel_valid), 0);
    start = 1'b1;
    ready_next_pixel = 1'b1;
    tick;
    start = 1'b0;
    ready_next_pixel = 1'b0;
    cur = 0;
    check("restart_done_clr", int'(frame_done), 0);
    check("restart_under_clr", int'(underrun), 0);
    check("restart_addr", int'(bram_addr), 0);
    wait_valid;
    check_pixel(0);

    // drawing_done at address 40
    while (cur < 40) advance;
    drawing_done = 1'b1;
    tick;
    check("t5_frame_done", int'(frame_done), 1);
    check("t5_valid", int'(pixel_valid), 0);
    tick;
    drawing_done = 1'b0;
    consume;
    tick;
    tick;
    tick;
    check("t5_addr_hold", int'(bram_addr), 40);
    check("t5_still_done", int'(frame_done), 1);
    check("t5_no_valid", int'(pixel_valid), 0);
    check("t5_done_consume", int'(underrun), 0);

    // Random frame with a threshold that changes between pixels
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom_range(0, 255));
    threshold = 8'($urandom_range(0, 255));
    do_reset;
    do_start;
    wait_valid;
    check_pixel(0);
    while (cur < 300) begin
      threshold = 8'($urandom_range(0, 255));
      advance;
    end

    // Asynchronous reset mid-frame at address 300
    #3 rst = 1'b1;
    #1 check_all_zero("t4_async");
    tick;
    rst = 1'b0;
    tick;
    do_start;
    check("t4_first_addr", int'(bram_addr), 0);
    check("t4_valid_low", int'(pixel_valid), 0);
    n = 0;
    while (!pixel_valid && n < 20) begin
      tick;
      n++;
    end
    check("t4_latency", n, RD_LAT + 1);
    check_pixel(0);

`ifdef FEEDER_DITHER_EN
    // Flat mid-grey under dither gives a checkerboard
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'd120;
    threshold = 8'd128;
    do_reset;
    do_start;
    wait_valid;
    check("t6_r0c0", int'(pixel_value_out), 0);
    advance;
    check("t6_r0c1", int'(pixel_value_out), 1);
    while (cur < 80) advance;
    check("t6_r1c0", int'(pixel_value_out), 1);
    advance;
    check("t6_r1c1", int'(pixel_value_out), 0);
`endif

    // Full all-black frame
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    threshold = 8'd128;
    do_reset;
    do_start;
    errs = 0;
    ones = 0;
    for (int i = 0; i < NPIX; i++) begin
      wait_valid;
      if (!pixel_valid) break;
      if (int'(pixel_value_out) != exp_pix(0, 128, i / COLS, i % COLS) ||
          int'(col_idx) != i % COLS || int'(row_idx) != i / COLS || int'(bram_addr) != i)
        errs++;
      ones += int'(pixel_value_out);
      consume;
    end
    check("t1_pixel_errs", errs, 0);
    check("t1_ones", ones, NPIX);
    check("t1_frame_done", int'(frame_done), 1);
    check("t1_valid", int'(pixel_valid), 0);
    check("t1_last_addr", int'(bram_addr), NPIX - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
